// File: rtl/gray_conv_arbiter_if.sv
// Request/result bundle for the two-requester Gray-to-binary converter.
// master = requesters/consumer side, slave = converter side.
interface gray_conv_arbiter_if #(
  parameter int W = 3
);
  logic         req0;
  logic         req1;
  logic [W-1:0] g0;
  logic [W-1:0] g1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] b_out;
  logic         b_valid;
  logic         b_src;
  logic         b_err;

  modport master (
    output req0, req1, g0, g1,
    input  gnt0, gnt1, b_out, b_valid, b_src, b_err
  );

  modport slave (
    input  req0, req1, g0, g1,
    output gnt0, gnt1, b_out, b_valid, b_src, b_err
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbitrated, bit-serial Gray-to-binary converter.
// Define GRAY_CHECK_EN to build in the per-requester Gray sequence checker.
module gray_conv_arbiter #(
  parameter int W = 3
) (
  input logic               clk,
  input logic               rst,
  gray_conv_arbiter_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          src_q, src_d;
  logic [W-1:0]  g_q, g_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic [W-1:0]  bout_q, bout_d;
  logic          bval_q, bval_d;
  logic          bsrc_q, bsrc_d;
  logic          berr_q, berr_d;
  logic          newbit;
  logic          win;
  logic          err_now;

`ifdef GRAY_CHECK_EN
  logic [W-1:0] hist0_q, hist1_q;
  logic         hv0_q, hv1_q;
  logic [W-1:0] prev;
  logic [W-1:0] diff;
  logic         hv;

  // Two or more differing bits: diff has more than one bit set.
  always_comb begin
    prev    = src_q ? hist1_q : hist0_q;
    hv      = src_q ? hv1_q : hv0_q;
    diff    = g_q ^ prev;
    err_now = hv & (|(diff & (diff - 1'b1)));
  end

  // History of the last converted code per requester, committed in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hv0_q   <= 1'b0;
      hv1_q   <= 1'b0;
    end else if (state_q == DONE) begin
      if (src_q) begin
        hist1_q <= g_q;
        hv1_q   <= 1'b1;
      end else begin
        hist0_q <= g_q;
        hv0_q   <= 1'b1;
      end
    end
  end
`else
  assign err_now = 1'b0;
`endif

  // Next-state and output logic for arbitration and serial conversion.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    g_d     = g_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    bout_d  = bout_q;
    bval_d  = 1'b0;
    bsrc_d  = bsrc_q;
    berr_d  = berr_q;
    win     = bus.req1 & (~bus.req0 | ~last_q);
    newbit  = acc_q[0] ^ g_q[idx_q];
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          src_d   = win;
          last_d  = win;
          g_d     = win ? bus.g1 : bus.g0;
          acc_d   = '0;
          idx_d   = CW'(W - 1);
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = {acc_q[W-2:0], newbit};
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = DONE;
          bout_d  = {acc_q[W-2:0], newbit};
          bval_d  = 1'b1;
          bsrc_d  = src_q;
          berr_d  = err_now;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      g_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      bout_q  <= '0;
      bval_q  <= 1'b0;
      bsrc_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      g_q     <= g_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      bout_q  <= bout_d;
      bval_q  <= bval_d;
      bsrc_q  <= bsrc_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.b_out   = bout_q;
  assign bus.b_valid = bval_q;
  assign bus.b_src   = bsrc_q;
  assign bus.b_err   = berr_q;
endmodule
